ddr_cmd_scheduler: RTL and testbench

// Front-end command scheduler for the DDR4 controller. Arbitrates host read/write requests

---
 rtl/ddr_cmd_scheduler_if.sv | 29 ++
 rtl/ddr_cmd_scheduler.sv | 279 +++++++++++++++++++++++++++
 tb/tb_ddr_cmd_scheduler.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_cmd_scheduler_if.sv
// Host request ports and DDR command bus of the DDR4 command scheduler.
// The scheduler takes the slave modport; the host/PHY side takes the master modport.
interface ddr_cmd_scheduler_if;
  logic        rd_req_valid;
  logic [29:0] rd_req_addr;
  logic        rd_req_ready;
  logic        wr_req_valid;
  logic [29:0] wr_req_addr;
  logic        wr_req_ready;
  logic        cmd_valid;
  logic [2:0]  cmd_code;
  logic [1:0]  cmd_bg;
  logic [1:0]  cmd_ba;
  logic [15:0] cmd_row;
  logic [9:0]  cmd_col;
  logic        busy;

  modport master (
    output rd_req_valid, rd_req_addr, wr_req_valid, wr_req_addr,
    input  rd_req_ready, wr_req_ready, cmd_valid, cmd_code, cmd_bg, cmd_ba,
           cmd_row, cmd_col, busy
  );

  modport slave (
    input  rd_req_valid, rd_req_addr, wr_req_valid, wr_req_addr,
    output rd_req_ready, wr_req_ready, cmd_valid, cmd_code, cmd_bg, cmd_ba,
           cmd_row, cmd_col, busy
  );
endinterface

// File: rtl/ddr_cmd_scheduler.sv
// DDR4 front-end command scheduler: round-robin RD/WR arbitration, per-bank open-row
// tracking and PRE/ACT/RD/WR sequencing with tRP/tRCD/tCCD/tWTR/tRTW spacing.
// Define REFRESH_EN to add periodic PREA/REF refresh (T_REFI/T_RFC).
module ddr_cmd_scheduler #(
  parameter int T_RCD = 14,
  parameter int T_RP  = 14,
  parameter int T_CCD = 4,
  parameter int T_WTR = 10,
  parameter int T_RTW = 6
`ifdef REFRESH_EN
  ,
  parameter int T_REFI = 3900,
  parameter int T_RFC  = 208
`endif
) (
  input logic                clock_t,
  input logic                reset,
  ddr_cmd_scheduler_if.slave bus
);

  localparam logic [2:0] CMD_NOP  = 3'd0;
  localparam logic [2:0] CMD_ACT  = 3'd1;
  localparam logic [2:0] CMD_RD   = 3'd2;
  localparam logic [2:0] CMD_WR   = 3'd3;
  localparam logic [2:0] CMD_PRE  = 3'd4;
`ifdef REFRESH_EN
  localparam logic [2:0] CMD_REF  = 3'd5;
  localparam logic [2:0] CMD_PREA = 3'd6;
`endif

  // Timers load T-1: the command register adds the remaining cycle before the bus sees it.
  localparam logic [15:0] LD_RCD = 16'(T_RCD - 1);
  localparam logic [15:0] LD_RP  = 16'(T_RP - 1);
  localparam logic [15:0] LD_CCD = 16'(T_CCD - 1);
  localparam logic [15:0] LD_WTR = 16'(T_WTR - 1);
  localparam logic [15:0] LD_RTW = 16'(T_RTW - 1);
`ifdef REFRESH_EN
  localparam logic [15:0] LD_RFC  = 16'(T_RFC - 1);
  localparam logic [15:0] LD_REFI = 16'(T_REFI - 1);
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_ACT,
    ST_COL,
    ST_PREA,
    ST_REF
  } state_e;

  state_e      state_q, state_d;
  logic [29:0] addr_q, addr_d;
  logic        dir_wr_q, dir_wr_d;
  logic        last_wr_q, last_wr_d;
  logic [15:0] open_q, open_d;
  logic [15:0] row_tab_q [16];
  logic [15:0] row_tab_d [16];
  logic [15:0] wait_q, wait_d;
  logic [15:0] ccd_q, ccd_d;
  logic [15:0] turn_q, turn_d;

  logic        cmd_valid_q, cmd_valid_d;
  logic [2:0]  cmd_code_q, cmd_code_d;
  logic [1:0]  cmd_bg_q, cmd_bg_d;
  logic [1:0]  cmd_ba_q, cmd_ba_d;
  logic [15:0] cmd_row_q, cmd_row_d;
  logic [9:0]  cmd_col_q, cmd_col_d;
  logic        rd_ready_q, rd_ready_d;
  logic        wr_ready_q, wr_ready_d;

`ifdef REFRESH_EN
  logic [15:0] ref_timer_q, ref_timer_d;
  logic        ref_pending_q, ref_pending_d;
`endif

  logic        rd_ok;
  logic        wr_ok;
  logic        grant_wr;
  logic [29:0] req_addr;
  logic [3:0]  req_bank;
  logic [3:0]  cur_bank;
  logic        req_row_hit;
  logic        turn_block;

  // A requester whose ready pulse is on the bus this cycle still shows its old request.
  assign rd_ok       = bus.rd_req_valid && !rd_ready_q;
  assign wr_ok       = bus.wr_req_valid && !wr_ready_q;
  assign grant_wr    = wr_ok && (!rd_ok || !last_wr_q);
  assign req_addr    = grant_wr ? bus.wr_req_addr : bus.rd_req_addr;
  assign req_bank    = req_addr[29:26];
  assign cur_bank    = addr_q[29:26];
  assign req_row_hit = open_q[req_bank] && (row_tab_q[req_bank] == req_addr[25:10]);
  assign turn_block  = (dir_wr_q != last_wr_q) && (turn_q != 16'd0);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    dir_wr_d    = dir_wr_q;
    last_wr_d   = last_wr_q;
    open_d      = open_q;
    row_tab_d   = row_tab_q;
    wait_d      = (wait_q != 16'd0) ? wait_q - 16'd1 : 16'd0;
    ccd_d       = (ccd_q  != 16'd0) ? ccd_q  - 16'd1 : 16'd0;
    turn_d      = (turn_q != 16'd0) ? turn_q - 16'd1 : 16'd0;
    cmd_valid_d = 1'b0;
    cmd_code_d  = CMD_NOP;
    cmd_bg_d    = 2'd0;
    cmd_ba_d    = 2'd0;
    cmd_row_d   = 16'd0;
    cmd_col_d   = 10'd0;
    rd_ready_d  = 1'b0;
    wr_ready_d  = 1'b0;
`ifdef REFRESH_EN
    ref_pending_d = ref_pending_q;
    ref_timer_d   = ref_timer_q;
`endif

    case (state_q)
      ST_IDLE: begin
`ifdef REFRESH_EN
        if (ref_pending_q) begin
          state_d = (|open_q) ? ST_PREA : ST_REF;
        end else
`endif
        if (rd_ok || wr_ok) begin
          addr_d   = req_addr;
          dir_wr_d = grant_wr;
          if (req_row_hit) begin
            state_d = ST_COL;
          end else if (open_q[req_bank]) begin
            state_d = ST_PRE;
          end else begin
            state_d = ST_ACT;
          end
        end
      end

      ST_PRE: begin
        if (wait_q == 16'd0) begin
          cmd_valid_d      = 1'b1;
          cmd_code_d       = CMD_PRE;
          cmd_bg_d         = addr_q[29:28];
          cmd_ba_d         = addr_q[27:26];
          wait_d           = LD_RP;
          open_d[cur_bank] = 1'b0;
          state_d          = ST_ACT;
        end
      end

      ST_ACT: begin
        if (wait_q == 16'd0) begin
          cmd_valid_d         = 1'b1;
          cmd_code_d          = CMD_ACT;
          cmd_bg_d            = addr_q[29:28];
          cmd_ba_d            = addr_q[27:26];
          cmd_row_d           = addr_q[25:10];
          wait_d              = LD_RCD;
          open_d[cur_bank]    = 1'b1;
          row_tab_d[cur_bank] = addr_q[25:10];
          state_d             = ST_COL;
        end
      end

      ST_COL: begin
        if ((wait_q == 16'd0) && (ccd_q == 16'd0) && !turn_block) begin
          cmd_valid_d = 1'b1;
          cmd_code_d  = dir_wr_q ? CMD_WR : CMD_RD;
          cmd_bg_d    = addr_q[29:28];
          cmd_ba_d    = addr_q[27:26];
          cmd_col_d   = addr_q[9:0];
          ccd_d       = LD_CCD;
          turn_d      = dir_wr_q ? LD_WTR : LD_RTW;
          rd_ready_d  = !dir_wr_q;
          wr_ready_d  = dir_wr_q;
          last_wr_d   = dir_wr_q;
          state_d     = ST_IDLE;
        end
      end

`ifdef REFRESH_EN
      ST_PREA: begin
        if (wait_q == 16'd0) begin
          cmd_valid_d = 1'b1;
          cmd_code_d  = CMD_PREA;
          wait_d      = LD_RP;
          open_d      = 16'd0;
          state_d     = ST_REF;
        end
      end

      ST_REF: begin
        if (wait_q == 16'd0) begin
          cmd_valid_d   = 1'b1;
          cmd_code_d    = CMD_REF;
          wait_d        = LD_RFC;
          open_d        = 16'd0;
          ref_pending_d = 1'b0;
          state_d       = ST_IDLE;
        end
      end
`endif

      default: state_d = ST_IDLE;
    endcase

`ifdef REFRESH_EN
    // Timer expiry wins over a REF clearing the flag in the same cycle.
    if (ref_timer_q == LD_REFI) begin
      ref_timer_d   = 16'd0;
      ref_pending_d = 1'b1;
    end else begin
      ref_timer_d = ref_timer_q + 16'd1;
    end
`endif
  end

  always_ff @(posedge clock_t or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= 30'd0;
      dir_wr_q    <= 1'b0;
      last_wr_q   <= 1'b1;
      open_q      <= 16'd0;
      row_tab_q   <= '{default: 16'd0};
      wait_q      <= 16'd0;
      ccd_q       <= 16'd0;
      turn_q      <= 16'd0;
      cmd_valid_q <= 1'b0;
      cmd_code_q  <= CMD_NOP;
      cmd_bg_q    <= 2'd0;
      cmd_ba_q    <= 2'd0;
      cmd_row_q   <= 16'd0;
      cmd_col_q   <= 10'd0;
      rd_ready_q  <= 1'b0;
      wr_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      dir_wr_q    <= dir_wr_d;
      last_wr_q   <= last_wr_d;
      open_q      <= open_d;
      row_tab_q   <= row_tab_d;
      wait_q      <= wait_d;
      ccd_q       <= ccd_d;
      turn_q      <= turn_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_code_q  <= cmd_code_d;
      cmd_bg_q    <= cmd_bg_d;
      cmd_ba_q    <= cmd_ba_d;
      cmd_row_q   <= cmd_row_d;
      cmd_col_q   <= cmd_col_d;
      rd_ready_q  <= rd_ready_d;
      wr_ready_q  <= wr_ready_d;
    end
  end

`ifdef REFRESH_EN
  always_ff @(posedge clock_t or posedge reset) begin
    if (reset) begin
      ref_timer_q   <= 16'd0;
      ref_pending_q <= 1'b0;
    end else begin
      ref_timer_q   <= ref_timer_d;
      ref_pending_q <= ref_pending_d;
    end
  end
`endif

  assign bus.cmd_valid    = cmd_valid_q;
  assign bus.cmd_code     = cmd_code_q;
  assign bus.cmd_bg       = cmd_bg_q;
  assign bus.cmd_ba       = cmd_ba_q;
  assign bus.cmd_row      = cmd_row_q;
  assign bus.cmd_col      = cmd_col_q;
  assign bus.rd_req_ready = rd_ready_q;
  assign bus.wr_req_ready = wr_ready_q;
  assign bus.busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ddr_cmd_scheduler.sv
// Scoreboard bench for ddr_cmd_scheduler: expected commands and their spacing are queued
// as requests are issued and matched against the command bus in order.
module tb_ddr_cmd_scheduler;

  localparam logic [2:0] CMD_NOP  = 3'd0;
  localparam logic [2:0] CMD_ACT  = 3'd1;
  localparam logic [2:0] CMD_RD   = 3'd2;
  localparam logic [2:0] CMD_WR   = 3'd3;
  localparam logic [2:0] CMD_PRE  = 3'd4;
  localparam logic [2:0] CMD_REF  = 3'd5;
  localparam logic [2:0] CMD_PREA = 3'd6;

  localparam int GAP_NONE  = 0;
  localparam int GAP_EXACT = 1;
  localparam int GAP_MIN   = 2;

  typedef struct {
    logic [2:0]  code;
    logic [1:0]  bg;
    logic [1:0]  ba;
    logic [15:0] row;
    logic [9:0]  col;
    int          gap;
    int          mode;
  } exp_t;

  logic clock_t = 1'b0;
  logic reset   = 1'b1;

  ddr_cmd_scheduler_if bus ();

`ifdef REFRESH_EN
  ddr_cmd_scheduler #(.T_REFI(200)) dut (
    .clock_t (clock_t),
    .reset   (reset),
    .bus     (bus)
  );
`else
  ddr_cmd_scheduler dut (
    .clock_t (clock_t),
    .reset   (reset),
    .bus     (bus)
  );
`endif

  always #5 clock_t = ~clock_t;

  exp_t        sb [$];
  logic [29:0] rd_host [$];
  logic [29:0] wr_host [$];
  int          vectors        = 0;
  int          miscompares    = 0;
  int          cycle          = 0;
  int          last_cmd_cycle = 0;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, observed, expected, cycle);
    end
  endtask

  function automatic logic [29:0] mk(input logic [1:0] bg, input logic [1:0] ba,
                                     input logic [15:0] row, input logic [9:0] col);
    return {bg, ba, row, col};
  endfunction

  task automatic applyStimulus(input bit is_wr, input logic [29:0] addr);
    if (is_wr) wr_host.push_back(addr);
    else       rd_host.push_back(addr);
  endtask

  task automatic pushExp(input logic [2:0] code, input logic [1:0] bg, input logic [1:0] ba,
                         input logic [15:0] row, input logic [9:0] col,
                         input int gap, input int mode);
    exp_t e;
    e.code = code; e.bg = bg; e.ba = ba; e.row = row; e.col = col;
    e.gap  = gap;  e.mode = mode;
    sb.push_back(e);
  endtask

  task automatic applyReset();
    @(negedge clock_t);
    reset = 1'b1;
    rd_host.delete();
    wr_host.delete();
    sb.delete();
    bus.rd_req_valid = 1'b0;
    bus.rd_req_addr  = 30'd0;
    bus.wr_req_valid = 1'b0;
    bus.wr_req_addr  = 30'd0;
    repeat (2) @(posedge clock_t);
    #1;
    checkOutput("rst_cmd_valid", 64'(bus.cmd_valid), 64'd0);
    checkOutput("rst_busy", 64'(bus.busy), 64'd0);
    checkOutput("rst_ready", 64'({bus.rd_req_ready, bus.wr_req_ready}), 64'd0);
    @(negedge clock_t);
    reset = 1'b0;
  endtask

  task automatic waitSb(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clock_t);
      n++;
    end
    if (n >= budget) checkOutput("sb_timeout", 64'(sb.size()), 64'd0);
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    int pending;
    pending = sb.size() + rd_host.size() + wr_host.size()
            + int'(bus.rd_req_valid) + int'(bus.wr_req_valid);
    while (pending != 0 && n < budget) begin
      @(negedge clock_t);
      n++;
      pending = sb.size() + rd_host.size() + wr_host.size()
              + int'(bus.rd_req_valid) + int'(bus.wr_req_valid);
    end
    if (n >= budget) checkOutput("drain_timeout", 64'(pending), 64'd0);
    repeat (3) @(negedge clock_t);
  endtask

  initial forever begin
    @(posedge clock_t);
    cycle++;
  end

  // Host model: hold each request until its ready pulse, then present the next one.
  initial begin
    bus.rd_req_valid = 1'b0;
    bus.rd_req_addr  = 30'd0;
    bus.wr_req_valid = 1'b0;
    bus.wr_req_addr  = 30'd0;
    forever begin
      @(negedge clock_t);
      if (!reset) begin
        if (bus.rd_req_valid && bus.rd_req_ready) begin
          if (rd_host.size() > 0) bus.rd_req_addr = rd_host.pop_front();
          else begin bus.rd_req_valid = 1'b0; bus.rd_req_addr = 30'd0; end
        end else if (!bus.rd_req_valid && rd_host.size() > 0) begin
          bus.rd_req_valid = 1'b1;
          bus.rd_req_addr  = rd_host.pop_front();
        end
        if (bus.wr_req_valid && bus.wr_req_ready) begin
          if (wr_host.size() > 0) bus.wr_req_addr = wr_host.pop_front();
          else begin bus.wr_req_valid = 1'b0; bus.wr_req_addr = 30'd0; end
        end else if (!bus.wr_req_valid && wr_host.size() > 0) begin
          bus.wr_req_valid = 1'b1;
          bus.wr_req_addr  = wr_host.pop_front();
        end
      end
    end
  end

  initial begin : monitor
    exp_t e;
    int   gap;
    forever begin
      @(negedge clock_t);
      if (!reset) begin
        if (bus.cmd_valid) begin
          gap = cycle - last_cmd_cycle;
          last_cmd_cycle = cycle;
          if (sb.size() == 0) begin
            checkOutput("unexpected_cmd", 64'(bus.cmd_code), 64'(CMD_NOP));
          end else begin
            e = sb.pop_front();
            checkOutput("cmd_code", 64'(bus.cmd_code), 64'(e.code));
            if (e.code != CMD_PREA && e.code != CMD_REF) begin
              checkOutput("cmd_bg", 64'(bus.cmd_bg), 64'(e.bg));
              checkOutput("cmd_ba", 64'(bus.cmd_ba), 64'(e.ba));
            end
            if (e.code == CMD_ACT) checkOutput("cmd_row", 64'(bus.cmd_row), 64'(e.row));
            if (e.code == CMD_RD || e.code == CMD_WR)
              checkOutput("cmd_col", 64'(bus.cmd_col), 64'(e.col));
            if (e.mode == GAP_EXACT) checkOutput("gap", 64'(gap), 64'(e.gap));
            else if (e.mode == GAP_MIN) checkOutput("gap_min", 64'(gap >= e.gap), 64'd1);
            checkOutput("rd_ready", 64'(bus.rd_req_ready), 64'(e.code == CMD_RD));
            checkOutput("wr_ready", 64'(bus.wr_req_ready), 64'(e.code == CMD_WR));
          end
        end else begin
          checkOutput("idle_bus", 64'({bus.cmd_code, bus.cmd_bg, bus.cmd_ba, bus.cmd_row,
                                       bus.cmd_col, bus.rd_req_ready, bus.wr_req_ready}),
                      64'd0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Closed bank: ACT then RD tRCD later.
    applyReset();
    applyStimulus(1'b0, mk(2'd0, 2'd0, 16'h0012, 10'h008));
    pushExp(CMD_ACT, 2'd0, 2'd0, 16'h0012, 10'h000, 0, GAP_NONE);
    pushExp(CMD_RD,  2'd0, 2'd0, 16'h0000, 10'h008, 14, GAP_EXACT);
    waitDrain(200);

    // Row hit back-to-back reads: a single ACT, reads tCCD apart.
    applyReset();
    applyStimulus(1'b0, mk(2'd1, 2'd2, 16'h0012, 10'h008));
    applyStimulus(1'b0, mk(2'd1, 2'd2, 16'h0012, 10'h010));
    pushExp(CMD_ACT, 2'd1, 2'd2, 16'h0012, 10'h000, 0, GAP_NONE);
    pushExp(CMD_RD,  2'd1, 2'd2, 16'h0000, 10'h008, 14, GAP_EXACT);
    pushExp(CMD_RD,  2'd1, 2'd2, 16'h0000, 10'h010, 4, GAP_EXACT);
    waitDrain(200);

    // Row conflict in the same bank: PRE, ACT after tRP, RD after tRCD.
    applyReset();
    applyStimulus(1'b0, mk(2'd2, 2'd3, 16'h0012, 10'h001));
    applyStimulus(1'b0, mk(2'd2, 2'd3, 16'h0034, 10'h002));
    pushExp(CMD_ACT, 2'd2, 2'd3, 16'h0012, 10'h000, 0, GAP_NONE);
    pushExp(CMD_RD,  2'd2, 2'd3, 16'h0000, 10'h001, 14, GAP_EXACT);
    pushExp(CMD_PRE, 2'd2, 2'd3, 16'h0000, 10'h000, 0, GAP_NONE);
    pushExp(CMD_ACT, 2'd2, 2'd3, 16'h0034, 10'h000, 14, GAP_EXACT);
    pushExp(CMD_RD,  2'd2, 2'd3, 16'h0000, 10'h002, 14, GAP_EXACT);
    waitDrain(300);

    // Both directions pending on one open row: alternation with turnaround spacing.
    applyReset();
    for (int i = 1; i <= 3; i++) applyStimulus(1'b0, mk(2'd3, 2'd1, 16'h0055, 10'(i)));
    for (int i = 4; i <= 5; i++) applyStimulus(1'b1, mk(2'd3, 2'd1, 16'h0055, 10'(i)));
    pushExp(CMD_ACT, 2'd3, 2'd1, 16'h0055, 10'h000, 0, GAP_NONE);
    pushExp(CMD_RD,  2'd3, 2'd1, 16'h0000, 10'h001, 14, GAP_EXACT);
    pushExp(CMD_WR,  2'd3, 2'd1, 16'h0000, 10'h004, 6, GAP_MIN);
    pushExp(CMD_RD,  2'd3, 2'd1, 16'h0000, 10'h002, 10, GAP_MIN);
    pushExp(CMD_WR,  2'd3, 2'd1, 16'h0000, 10'h005, 6, GAP_MIN);
    pushExp(CMD_RD,  2'd3, 2'd1, 16'h0000, 10'h003, 10, GAP_MIN);
    waitDrain(400);

    // Reset in the middle of a sequence: request is re-issued from ACT.
    applyReset();
    applyStimulus(1'b0, mk(2'd0, 2'd1, 16'h0077, 10'h003));
    pushExp(CMD_ACT, 2'd0, 2'd1, 16'h0077, 10'h000, 0, GAP_NONE);
    waitSb(100);
    repeat (5) @(posedge clock_t);
    #2;
    checkOutput("busy_before_reset", 64'(bus.busy), 64'd1);
    reset = 1'b1;
    #1;
    checkOutput("mid_reset_outputs", 64'({bus.cmd_valid, bus.busy, bus.rd_req_ready,
                                          bus.cmd_code, bus.cmd_row}), 64'd0);
    pushExp(CMD_ACT, 2'd0, 2'd1, 16'h0077, 10'h000, 0, GAP_NONE);
    pushExp(CMD_RD,  2'd0, 2'd1, 16'h0000, 10'h003, 14, GAP_EXACT);
    repeat (2) @(negedge clock_t);
    reset = 1'b0;
    waitDrain(200);

`ifdef REFRESH_EN
    // Refresh with a bank open: PREA, REF tRP later, next ACT tRFC after REF.
    applyReset();
    applyStimulus(1'b0, mk(2'd0, 2'd0, 16'h0012, 10'h008));
    pushExp(CMD_ACT, 2'd0, 2'd0, 16'h0012, 10'h000, 0, GAP_NONE);
    pushExp(CMD_RD,  2'd0, 2'd0, 16'h0000, 10'h008, 14, GAP_EXACT);
    waitSb(100);
    pushExp(CMD_PREA, 2'd0, 2'd0, 16'h0000, 10'h000, 0, GAP_NONE);
    pushExp(CMD_REF,  2'd0, 2'd0, 16'h0000, 10'h000, 14, GAP_EXACT);
    waitSb(400);
    applyStimulus(1'b0, mk(2'd0, 2'd0, 16'h0034, 10'h001));
    pushExp(CMD_ACT,  2'd0, 2'd0, 16'h0034, 10'h000, 208, GAP_EXACT);
    pushExp(CMD_RD,   2'd0, 2'd0, 16'h0000, 10'h001, 14, GAP_EXACT);
    pushExp(CMD_PREA, 2'd0, 2'd0, 16'h0000, 10'h000, 0, GAP_NONE);
    pushExp(CMD_REF,  2'd0, 2'd0, 16'h0000, 10'h000, 14, GAP_EXACT);
    waitDrain(600);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
